// File: rtl/cache_sa_rd.sv
// N-way set-associative read-only cache with age-based LRU replacement,
// single-cycle flush and saturating hit/miss counters.
module cache_sa_rd #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         flush,
  output logic                         busywait,
  output logic [WORD_W-1:0]            readdata,
  output logic                         mem_read,
  output logic [ADDR_W-1:0]            mem_address,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_readdata,
  input  logic                         mem_busywait,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int unsigned BO_W   = $clog2(WORD_W / 8);
  localparam int unsigned WO_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - BO_W - WO_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = WORD_W * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, MEM_RD, FILL} state_t;

  state_t            state;
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [WAY_W-1:0]  age_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];

  logic [TAG_W-1:0]  m_tag;
  logic [IDX_W-1:0]  m_idx;
  logic [WAY_W-1:0]  m_way;
  logic [LINE_W-1:0] line_q;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [WO_W-1:0]   a_wo;
  logic              unused_byte_ofs;

  assign a_tag           = address[ADDR_W-1 -: TAG_W];
  assign a_idx           = address[BO_W+WO_W +: IDX_W];
  assign a_wo            = address[BO_W +: WO_W];
  assign unused_byte_ofs = ^address[BO_W-1:0];

  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;
  logic              inv_found;
  logic [WAY_W-1:0]  victim;

  // Tag lookup and victim choice for the addressed set
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    victim    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[a_idx][w] && (tag_q[a_idx][w] == a_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[a_idx][w]) begin
        inv_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && (age_q[a_idx][w] == WAY_W'(WAYS - 1))) victim = WAY_W'(w);
    end
  end

  always_comb begin
    hit_line = data_q[a_idx][hit_way];
    hit_word = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (WO_W'(i) == a_wo) hit_word = hit_line[i*WORD_W +: WORD_W];
    end
  end

  logic lookup_hit;
  assign lookup_hit = (state == IDLE) && read && !flush && hit_any;

  assign busywait = (state != IDLE) || flush || (read && !hit_any);
  assign readdata = lookup_hit ? hit_word : '0;

  // Recency touch: a hit in IDLE or the completing fill
  logic             touch_en;
  logic [IDX_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;

  always_comb begin
    touch_en  = 1'b0;
    touch_set = a_idx;
    touch_way = hit_way;
    if (lookup_hit) begin
      touch_en = 1'b1;
    end else if (state == FILL) begin
      touch_en  = 1'b1;
      touch_set = m_idx;
      touch_way = m_way;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age_q[touch_set][w] <= '0;
        else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
          age_q[touch_set][w] <= age_q[touch_set][w] + WAY_W'(1);
      end
    end
  end

  // Tag/data arrays carry no reset
  always_ff @(posedge clk) begin
    if (!reset && (state == FILL)) begin
      data_q[m_idx][m_way] <= line_q;
      tag_q[m_idx][m_way]  <= m_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      m_tag       <= '0;
      m_idx       <= '0;
      m_way       <= '0;
      line_q      <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end else if (read && hit_any) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else if (read) begin
            m_tag       <= a_tag;
            m_idx       <= a_idx;
            m_way       <= victim;
            mem_read    <= 1'b1;
            mem_address <= {a_tag, a_idx, (WO_W + BO_W)'(0)};
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            state       <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (!mem_busywait) begin
            line_q   <= mem_readdata;
            mem_read <= 1'b0;
            state    <= FILL;
          end
        end
        FILL: begin
          valid_q[m_idx][m_way] <= 1'b1;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa_rd.sv
// Bench for cache_sa_rd: directed vector table, reset/saturation sequences
// and a randomized phase checked against a recency-list cache model.
module tb_cache_sa_rd;

  localparam int unsigned SETS = 16;
  localparam int unsigned WAYS = 2;

  logic         clk = 1'b0;
  logic         reset, read, flush;
  logic [31:0]  address;
  logic         busywait, mem_read, mem_busywait;
  logic [31:0]  readdata, mem_address;
  logic [127:0] mem_readdata;
  logic [15:0]  hit_count, miss_count;

  logic         read2;
  logic [31:0]  address2;
  logic         flush2, busywait2, mem_read2, mem_busywait2;
  logic [31:0]  readdata2, mem_address2;
  logic [127:0] mem_readdata2;
  logic [1:0]   hit2, miss2;

  always #5 clk = ~clk;

  cache_sa_rd #(.ADDR_W(32), .WORD_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .read(read), .address(address), .flush(flush),
    .busywait(busywait), .readdata(readdata), .mem_read(mem_read), .mem_address(mem_address),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count));

  cache_sa_rd #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .read(read2), .address(address2), .flush(flush2),
    .busywait(busywait2), .readdata(readdata2), .mem_read(mem_read2), .mem_address(mem_address2),
    .mem_readdata(mem_readdata2), .mem_busywait(mem_busywait2),
    .hit_count(hit2), .miss_count(miss2));

  function automatic logic [31:0] wdata(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory: mem_busywait held for mem_delay-1 cycles of each request
  int mem_delay = 1;
  int mem_cnt = 0;
  always @(posedge clk) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
  assign mem_busywait  = mem_read && (mem_cnt < mem_delay - 1);
  assign mem_busywait2 = 1'b0;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_readdata[i*32 +: 32]  = wdata(mem_address + 32'(i * 4));
      mem_readdata2[i*32 +: 32] = wdata(mem_address2 + 32'(i * 4));
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: per-set recency list, most recent first
  bit          m_valid [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  int          m_lru   [SETS][WAYS];
  int          m_hits, m_miss;

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_lru[s][w]   = w;
      end
    m_hits = 0;
    m_miss = 0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int idx = int'(a[7:4]);
    int way = -1;
    int pos = 0;
    bit hit;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == a[31:8]) way = w;
    hit = (way >= 0);
    if (!hit) begin
      if (m_miss < 65535) m_miss++;
      for (int w = 0; w < WAYS; w++)
        if (way < 0 && !m_valid[idx][w]) way = w;
      if (way < 0) way = m_lru[idx][WAYS-1];
      m_valid[idx][way] = 1'b1;
      m_tag[idx][way]   = a[31:8];
    end
    for (int p = 0; p < WAYS; p++) if (m_lru[idx][p] == way) pos = p;
    for (int p = pos; p > 0; p--) m_lru[idx][p] = m_lru[idx][p-1];
    m_lru[idx][0] = way;
    if (m_hits < 65535) m_hits++;
    return hit;
  endfunction

  // One CPU read: fl=1 flush cycle before, fl=2 flush in the first cycle
  task automatic do_read(input logic [31:0] a, input int d, input int fl,
                         output int busy, output logic [31:0] rd,
                         output bit saw_mrd, output logic [31:0] maddr);
    bit done = 1'b0;
    if (fl == 1) begin
      flush = 1'b1;
      @(negedge clk);
      chk("flush_busy", 64'(busywait), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    mem_delay = d;
    address = a;
    read = 1'b1;
    flush = (fl == 2);
    busy = 0;
    saw_mrd = 1'b0;
    maddr = '0;
    rd = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (mem_read) begin
        saw_mrd = 1'b1;
        maddr = mem_address;
      end
      if (!busywait) begin
        done = 1'b1;
        break;
      end
      busy++;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    if (!done) chk("read_timeout", 64'd1, 64'd0);
    rd = readdata;
    @(posedge clk); #1;
    read = 1'b0;
    flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          d;
    int          fl;
    int          exp_busy;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          busy;
    logic [31:0] rd, maddr, a;
    bit          saw, hit;
    int          d, fl, exp_busy;
    logic [23:0] tags [4];
    logic [3:0]  idxs [4];

    tbl[0] = '{32'h8000_019E, 3, 0, 5, 1, 1};
    tbl[1] = '{32'h8000_0194, 3, 0, 0, 2, 1};
    tbl[2] = '{32'h0000_0290, 2, 0, 4, 3, 2};
    tbl[3] = '{32'h8000_0190, 1, 0, 0, 4, 2};
    tbl[4] = '{32'h0000_0398, 1, 0, 3, 5, 3};
    tbl[5] = '{32'h8000_019C, 1, 0, 0, 6, 3};
    tbl[6] = '{32'h0000_0290, 2, 0, 4, 7, 4};
    tbl[7] = '{32'h8000_019E, 3, 1, 5, 8, 5};
    tbl[8] = '{32'h8000_019E, 2, 2, 5, 9, 6};
    tbl[9] = '{32'h0000_0294, 4, 0, 6, 10, 7};

    reset = 1'b1; read = 1'b0; flush = 1'b0; address = '0;
    read2 = 1'b0; flush2 = 1'b0; address2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busywait", 64'(busywait), 64'd0);
    chk("rst_readdata", 64'(readdata), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_miss", 64'(miss_count), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_read(tbl[i].addr, tbl[i].d, tbl[i].fl, busy, rd, saw, maddr);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      chk($sformatf("vec%0d_data", i), 64'(rd), 64'(wdata(tbl[i].addr)));
      chk($sformatf("vec%0d_hits", i), 64'(hit_count), 64'(tbl[i].exp_hits));
      chk($sformatf("vec%0d_miss", i), 64'(miss_count), 64'(tbl[i].exp_miss));
      chk($sformatf("vec%0d_mrd", i), 64'(saw), 64'(tbl[i].exp_busy != 0));
      if (tbl[i].exp_busy != 0)
        chk($sformatf("vec%0d_maddr", i), 64'(maddr), 64'(tbl[i].addr & 32'hFFFF_FFF0));
    end

    // Idle cycle: nothing looked up or counted
    @(negedge clk);
    chk("idle_busy", 64'(busywait), 64'd0);
    chk("idle_data", 64'(readdata), 64'd0);
    @(posedge clk); #1;
    chk("idle_hits", 64'(hit_count), 64'd10);

    // Reset two cycles into a refill
    mem_delay = 8;
    address = 32'h1234_5670;
    read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rrd_mem_read_before", 64'(mem_read), 64'd1);
    reset = 1'b1;
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rrd_mem_read_after", 64'(mem_read), 64'd0);
    chk("rrd_hits", 64'(hit_count), 64'd0);
    chk("rrd_miss", 64'(miss_count), 64'd0);
    chk("rrd_busy", 64'(busywait), 64'd0);
    @(posedge clk); #1;
    model_reset();
    foreach (tags[k]) begin
      tags[k] = 24'(k == 0 ? 24'h800001 : (k == 1 ? 24'h000002 : (k == 2 ? 24'h000003 : 24'h7FFFFF)));
      idxs[k] = 4'(k == 0 ? 9 : (k == 1 ? 0 : (k == 2 ? 15 : 3)));
    end
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'h1234_5670 : 32'h8000_019E;
      hit = model_access(a);
      do_read(a, 2, 0, busy, rd, saw, maddr);
      chk("post_rst_busy", 64'(busy), 64'(hit ? 0 : 4));
      chk("post_rst_data", 64'(rd), 64'(wdata(a)));
      chk("post_rst_miss", 64'(miss_count), 64'(m_miss));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      d = int'($urandom_range(1, 4));
      fl = int'($urandom_range(0, 19));
      fl = (fl < 2) ? 1 : ((fl == 2) ? 2 : 0);
      if (fl != 0) model_flush();
      hit = model_access(a);
      exp_busy = (fl == 2 ? 1 : 0) + (hit ? 0 : d + 2);
      do_read(a, d, fl, busy, rd, saw, maddr);
      chk($sformatf("rnd%0d_busy", i), 64'(busy), 64'(exp_busy));
      chk($sformatf("rnd%0d_data", i), 64'(rd), 64'(wdata(a)));
      chk($sformatf("rnd%0d_hits", i), 64'(hit_count), 64'(m_hits));
      chk($sformatf("rnd%0d_miss", i), 64'(miss_count), 64'(m_miss));
      if (!hit) chk($sformatf("rnd%0d_maddr", i), 64'(maddr), 64'(a & 32'hFFFF_FFF0));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk($sformatf("rnd%0d_idle_busy", i), 64'(busywait), 64'd0);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d_idle_hits", i), 64'(hit_count), 64'(m_hits));
      end
    end

    // Counter saturation on the narrow-counter instance
    for (int i = 0; i < 5; i++) begin
      bit done2 = 1'b0;
      address2 = 32'h0000_0048;
      read2 = 1'b1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (!busywait2) begin
          done2 = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!done2) chk("sat_timeout", 64'd1, 64'd0);
      chk($sformatf("sat%0d_data", i), 64'(readdata2), 64'(wdata(32'h0000_0048)));
      @(posedge clk); #1;
      read2 = 1'b0;
      chk($sformatf("sat%0d_hits", i), 64'(hit2), 64'(i + 1 > 3 ? 3 : i + 1));
    end
    chk("sat_miss", 64'(miss2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_sa_rd.md
Name: cache_sa_rd

Overview:
- Parametrised N-way set-associative, read-only cache. Successor to the direct-mapped cache.
- Sits between the CPU fetch/load port and the line-wide data memory.
- Adds configurable sets, ways and line size; age-based LRU replacement; a single-cycle flush; hit/miss statistics counters.
- Uses the same busywait handshake on both the CPU side and the memory side.

Parameters:
- ADDR_W, 32, address width.
- WORD_W, 32, CPU word width.
- SETS, 16, number of sets (power of 2).
- WAYS, 2, associativity (power of 2, ≥2).
- LINE_WORDS, 4, words per line (power of 2).
- CNT_W, 16, width of the statistics counters.
- Address split, LSB first:
  - byte offset: log2(WORD_W/8) bits
  - word offset: log2(LINE_WORDS) bits
  - index: log2(SETS) bits
  - tag: remaining bits
  - Defaults give 2/2/4/24.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  CPU read request.
- address  in  ADDR_W  CPU byte address.
- flush  in  1  invalidate all lines.
- busywait  out  1  CPU must hold read/address stable while high.
- readdata  out  WORD_W  selected word, valid when read=1 and busywait=0.
- mem_read  out  1  line refill request.
- mem_address  out  ADDR_W  line-aligned refill address (word-offset and byte bits zero).
- mem_readdata  in  WORD_W*LINE_WORDS  refill line; word 0 in the LSBs.
- mem_busywait  in  1  memory busy; line is valid on the edge where mem_busywait=0 while mem_read=1.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state = IDLE; all valid bits cleared.
  - Ages of way w in every set = w.
  - mem_read = 0; hit_count = miss_count = 0.
  - busywait = 0 (with read = 0); readdata = 0.
  - Tag/data arrays are not cleared.
- States:
  - IDLE: lookup. hit = read & OR over ways of (valid & tag match).
    - On hit: busywait = 0 combinationally; readdata = selected word in the same cycle. On the edge: ages updated, hit_count incremented.
    - On miss: busywait = 1 in the same cycle. On the edge: latch tag/index into a miss register, select a victim way, increment miss_count, go to MEM_RD.
  - MEM_RD: mem_read = 1; mem_address = {latched tag, latched index, zeros}; busywait = 1.
    - Stay while mem_busywait = 1.
    - At the edge where mem_busywait = 0: capture the line, go to FILL.
  - FILL: mem_read = 0; busywait = 1.
    - On the edge: write data, tag, valid = 1 into the victim way; go to IDLE.
    - The request is then re-looked-up in IDLE and hits; that hit is counted.
- Miss latency: busywait high for (memory cycles + 2) cycles.
- Victim selection:
  - Lowest-numbered invalid way if any.
  - Otherwise the way with age = WAYS-1.
- Age update (on hit or fill of way h): ways with age < age[h] increment; way h set to 0. Ages in a set remain a permutation of 0..WAYS-1.
- read = 0: no lookup, no age or counter change, busywait = 0, readdata = 0.
- flush = 1:
  - In IDLE: all valid bits cleared on the edge; busywait = 1 that cycle; a concurrent read is treated as a miss on the next cycle.
  - In MEM_RD or FILL: flush is ignored.
- Counters saturate at 2^CNT_W - 1.
- Reset during MEM_RD or FILL: abandon the refill; mem_read = 0 after the edge; no array write.
- A change of address during MEM_RD/FILL violates the protocol; the refill uses the latched address regardless.

Test Plan:
- Reset, then read 0x8000019E (tag 0x800001, idx 9, word 3) with memory delay 3 cycles:
  - mem_read = 1, mem_address = 0x80000190.
  - busywait high 5 cycles; readdata = word 3 of the line.
  - miss_count = 1, hit_count = 1.
- Immediately read 0x80000194 (same line, word 1) -> busywait = 0 in the same cycle; readdata = word 1; hit_count = 2.
- Fill tags A, B, C to idx 9 in turn (WAYS = 2), touching A between B and C:
  - C evicts B.
  - Re-read A hits; re-read B misses.
- flush = 1 in IDLE, then re-read 0x8000019E -> miss, new refill, miss_count increments.
- Assert reset two cycles into MEM_RD -> mem_read = 0 next cycle; valid bits = 0; counters = 0; a subsequent read of the same address misses.
- With CNT_W = 2, perform 5 hits -> hit_count saturates at 3.
